// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit and the decoder that drives it.
package mdu_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned RD_W  = 2;

  typedef enum logic [OP_W-1:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6
  } mduop_e;

  localparam logic [RD_W-1:0] READ_NONE = 2'd0;
  localparam logic [RD_W-1:0] READ_HI   = 2'd1;
  localparam logic [RD_W-1:0] READ_LO   = 2'd2;

  localparam logic [CNT_W-1:0] T_MULT = 4'd5;
  localparam logic [CNT_W-1:0] T_DIV  = 4'd10;

  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } hilo_t;

  // True for the ops that occupy the unit for a multicycle latency.
  function automatic logic is_launch(input logic [OP_W-1:0] op);
    return (op >= OP_W'(MDU_MULT)) && (op <= OP_W'(MDU_DIVU));
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Operand/control bundle from the E stage into the multiply/divide unit and its results back.
interface mult_div_unit_if;
  import mdu_pkg::*;

  logic             Start;
  logic [OP_W-1:0]  MDUOP;
  logic [CNT_W-1:0] Time;
  logic [RD_W-1:0]  ReadHILO;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic [WIDTH-1:0] MDOut;

  modport master (
    output Start, MDUOP, Time, ReadHILO, A, B,
    input  Busy, HI, LO, MDOut
  );

  modport slave (
    input  Start, MDUOP, Time, ReadHILO, A, B,
    output Busy, HI, LO, MDOut
  );

endinterface

// File: rtl/mdu_compute.sv
// Combinational datapath: 64-bit products and quotient/remainder pairs packed as {hi, lo}.
module mdu_compute
  import mdu_pkg::*;
(
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [OP_W-1:0]  i_op,
  output hilo_t            o_res,
  output logic             o_div_zero
);

  localparam int unsigned DW = 2 * WIDTH;

  logic                    w_b_zero;
  logic [WIDTH-1:0]        w_b_safe;
  logic signed [DW-1:0]    w_prod_s;
  logic [DW-1:0]           w_prod_u;
  logic signed [WIDTH-1:0] w_quot_s;
  logic signed [WIDTH-1:0] w_rem_s;
  logic [WIDTH-1:0]        w_quot_u;
  logic [WIDTH-1:0]        w_rem_u;

  // Divisor forced non-zero so the dividers never see 0; the result is discarded upstream then.
  assign w_b_zero = (i_b == '0);
  assign w_b_safe = w_b_zero ? WIDTH'(1) : i_b;

  assign w_prod_s = $signed({{WIDTH{i_a[WIDTH-1]}}, i_a}) * $signed({{WIDTH{i_b[WIDTH-1]}}, i_b});
  assign w_prod_u = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

  // Signed division truncates toward zero; remainder takes the dividend's sign.
  assign w_quot_s = $signed(i_a) / $signed(w_b_safe);
  assign w_rem_s  = $signed(i_a) % $signed(w_b_safe);
  assign w_quot_u = i_a / w_b_safe;
  assign w_rem_u  = i_a % w_b_safe;

  always_comb begin
    o_res      = '0;
    o_div_zero = 1'b0;
    case (i_op)
      MDU_MULT:  o_res = hilo_t'(w_prod_s);
      MDU_MULTU: o_res = hilo_t'(w_prod_u);
      MDU_DIV: begin
        o_res.hi   = w_rem_s;
        o_res.lo   = w_quot_s;
        o_div_zero = w_b_zero;
      end
      MDU_DIVU: begin
        o_res.hi   = w_rem_u;
        o_res.lo   = w_quot_u;
        o_div_zero = w_b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multiply/divide unit: owns HI/LO, commits results after a programmable countdown, drives Busy.
module mult_div_unit
  import mdu_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  mult_div_unit_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  hilo_t            r_arch;
  hilo_t            r_shadow;

  hilo_t            w_res;
  logic             w_div_zero;
  logic [CNT_W-1:0] w_time_eff;
  logic [WIDTH-1:0] w_mdout;

  mdu_compute u_compute (
    .i_a        (bus.A),
    .i_b        (bus.B),
    .i_op       (bus.MDUOP),
    .o_res      (w_res),
    .o_div_zero (w_div_zero)
  );

  // A zero latency request still occupies the unit for one cycle.
  assign w_time_eff = (bus.Time == '0) ? CNT_W'(1) : bus.Time;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_arch   <= '0;
      r_shadow <= '0;
    end else if (r_state == ST_IDLE) begin
      if (bus.Start && is_launch(bus.MDUOP)) begin
        r_shadow <= w_div_zero ? r_arch : w_res;
        r_cnt    <= w_time_eff;
        r_busy   <= 1'b1;
        r_state  <= ST_RUN;
      end else if (bus.MDUOP == OP_W'(MDU_MTHI)) begin
        r_arch.hi <= bus.A;
      end else if (bus.MDUOP == OP_W'(MDU_MTLO)) begin
        r_arch.lo <= bus.A;
      end
    end else begin
      // Requests arriving while running are ignored; commit on the last countdown edge.
      if (r_cnt == CNT_W'(1)) begin
        r_arch  <= r_shadow;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
        r_state <= ST_IDLE;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_mdout = '0;
    case (bus.ReadHILO)
      READ_HI: w_mdout = r_arch.hi;
      READ_LO: w_mdout = r_arch.lo;
      default: ;
    endcase
  end

  assign bus.Busy  = r_busy;
  assign bus.HI    = r_arch.hi;
  assign bus.LO    = r_arch.lo;
  assign bus.MDOut = w_mdout;

endmodule
